// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

  // func3 encodings of the M extension
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // func7 tag that marks an R-type op as an M-extension op (decoded upstream)
  localparam logic [6:0] M_FUNC7 = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // func3[2] separates the divide/remainder group from the multiplies
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // DIV and REM are signed, DIVU and REMU are not
  function automatic logic is_signed_div(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  // REM/REMU return the remainder
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request/result bundle between the pipeline and the mul/div unit.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rd;
  logic            flush;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  // pipeline side drives the op, reads back stall/result
  modport master (
    output start, func3, op1, op2, rd, flush,
    input  stall_req, busy, done, result, result_rd
  );

  // unit side
  modport slave (
    input  start, func3, op1, op2, rd, flush,
    output stall_req, busy, done, result, result_rd
  );
endinterface

// File: rtl/ex_muldiv_unit_div_iter_core.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step.
// The post-step values are exposed combinationally so the caller can
// register the final result on the same edge as the last step.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            fits;

  // shift next dividend bit into the partial remainder, trial-subtract
  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign fits    = ~diff[XLEN];
  assign quo_nxt = {quo_q[XLEN-2:0], fits};
  assign rem_nxt = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];

  // divider registers: quo_q doubles as the dividend shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (clr) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: single-cycle multiplies, iterative divides.
// Holds the pipeline front via stall_req until the result is ready and
// then presents it for exactly one cycle with done.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       rd_q;
  logic             rem_sel_q;
  logic             neg_q_q;
  logic             neg_r_q;

  logic             accept, load, step, abort, last, stall;
  logic             div_op, sgn_div, rem_op, div_zero, div_ovf;
  logic             a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]  mul_res, imm_res;
  logic [XLEN-1:0]  abs1, abs2;
  logic [XLEN-1:0]  quo_nxt, rem_nxt, quo_fix, rem_fix, div_res;

  // decode of the op presented this cycle
  assign div_op   = is_div_op(bus.func3);
  assign sgn_div  = is_signed_div(bus.func3);
  assign rem_op   = is_rem_op(bus.func3);
  assign div_zero = (bus.op2 == '0);
  assign div_ovf  = sgn_div && (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2 == '1);

  // operands extended to 2*XLEN make the modulo-2^64 product equal the
  // low 64 bits of the 33x33 signed product for every MUL variant
  assign a_sgn   = (bus.func3 == F3_MULH) || (bus.func3 == F3_MULHSU);
  assign b_sgn   = (bus.func3 == F3_MULH);
  assign a_ext   = {{XLEN{a_sgn & bus.op1[XLEN-1]}}, bus.op1};
  assign b_ext   = {{XLEN{b_sgn & bus.op2[XLEN-1]}}, bus.op2};
  assign prod    = a_ext * b_ext;
  assign mul_res = (bus.func3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // results that are known in the accept cycle (multiplies, divide corners)
  always_comb begin
    imm_res = mul_res;
    if (div_op) begin
      if (div_zero) imm_res = rem_op ? bus.op1 : '1;
      else          imm_res = rem_op ? '0 : bus.op1;  // overflow: quotient = op1
    end
  end

  // magnitudes for the unsigned core
  assign abs1 = (sgn_div && bus.op1[XLEN-1]) ? -bus.op1 : bus.op1;
  assign abs2 = (sgn_div && bus.op2[XLEN-1]) ? -bus.op2 : bus.op2;

  div_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .load     (load),
    .step     (step),
    .dividend (abs1),
    .divisor  (abs2),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // sign fix applied to the values produced by the final step
  assign quo_fix = neg_q_q ? -quo_nxt : quo_nxt;
  assign rem_fix = neg_r_q ? -rem_nxt : rem_nxt;
  assign div_res = rem_sel_q ? rem_fix : quo_fix;
  assign last    = (cnt_q == CNT_W'(XLEN-1));

  // next-state and control decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    abort   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          accept = 1'b1;
          stall  = 1'b1;
          if (div_op && !div_zero && !div_ovf) begin
            load    = 1'b1;
            state_d = ST_DIV_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DIV_RUN: begin
        stall = 1'b1;
        if (bus.flush) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.stall_req = stall;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // per-op context latched at accept, iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rd_q      <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
    end else begin
      if (accept) begin
        rd_q      <= bus.rd;
        rem_sel_q <= rem_op;
        neg_q_q   <= sgn_div & (bus.op1[XLEN-1] ^ bus.op2[XLEN-1]);
        neg_r_q   <= sgn_div & bus.op1[XLEN-1];
      end
      if (load)      cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // result registers only change when a result is committed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.result    <= '0;
      bus.result_rd <= '0;
    end else if (accept && !load) begin
      bus.result    <= imm_res;
      bus.result_rd <= bus.rd;
    end else if (step && last) begin
      bus.result    <= div_res;
      bus.result_rd <= rd_q;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: multiplies, divides, corner cases,
// flush abort and mid-divide reset.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // issue one op at cycle T, expect done exactly at T+lat
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp, input int lat);
    int bad;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.func3 = f3; bus.op1 = a; bus.op2 = b; bus.rd = r;
    @(negedge clk);
    chk({tag, " stall@T"}, {31'd0, bus.stall_req}, 32'd1);
    @(posedge clk); #1;
    // scramble inputs: the unit must work from what it latched
    bus.start = 1'b0; bus.op1 = 32'hDEAD_BEEF; bus.op2 = 32'h0BAD_F00D; bus.rd = 5'd0;
    bad = 0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (bus.stall_req !== 1'b1 || bus.done !== 1'b0) bad++;
    end
    if (lat > 1) chk({tag, " stall window"}, bad, 0);
    @(negedge clk);
    chk({tag, " done"},  {31'd0, bus.done},      32'd1);
    chk({tag, " stall@done"}, {31'd0, bus.stall_req}, 32'd0);
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " rd"},    {27'd0, bus.result_rd}, {27'd0, r});
  endtask

  initial begin
    int bad;
    n_chk = 0; n_err = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.func3 = 3'd0; bus.op1 = '0; bus.op2 = '0;
    bus.rd = 5'd0; bus.flush = 1'b0;
    #3;
    chk("rst busy",   {31'd0, bus.busy},      32'd0);
    chk("rst done",   {31'd0, bus.done},      32'd0);
    chk("rst stall",  {31'd0, bus.stall_req}, 32'd0);
    chk("rst result", bus.result,             32'd0);
    chk("rst rd",     {27'd0, bus.result_rd}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // multiplies
    run_op("MUL",    F3_MUL,    32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1);
    run_op("MUL2",   F3_MUL,    32'h1234_5678, 32'h0000_0010, 5'd4,  32'h2345_6780, 1);
    run_op("MULH",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 1);
    run_op("MULHU",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1);
    run_op("MULHSU", F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'hFFFF_FFFF, 1);

    // iterative divides
    run_op("DIV",    F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 33);
    run_op("REM",    F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 33);
    run_op("DIVneg", F3_DIV,    32'd20,        32'hFFFF_FFFA, 5'd10, 32'hFFFF_FFFD, 33);
    run_op("REMneg", F3_REM,    32'd20,        32'hFFFF_FFFA, 5'd11, 32'd2,         33);
    run_op("REMU",   F3_REMU,   32'd100,       32'd7,         5'd12, 32'd2,         33);

    // single-cycle divide corners
    run_op("DIVU/0", F3_DIVU,   32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run_op("REMU/0", F3_REMU,   32'h1234,      32'd0,         5'd14, 32'h0000_1234, 1);
    run_op("REM/0",  F3_REM,    32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFB, 1);
    run_op("DIVovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op("REMovf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1);

    // flush at T+10 aborts a divide; MUL issued at T+11 completes at T+12
    @(posedge clk); #1;
    bus.start = 1'b1; bus.func3 = F3_DIV; bus.op1 = 32'd1000; bus.op2 = 32'd3; bus.rd = 5'd20;
    @(posedge clk); #1;                       // T+1
    bus.start = 1'b0;
    bad = 0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end                                       // now in T+10
    chk("flush pre-window", bad, 0);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush busy@T+10", {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;                       // T+11
    bus.flush = 1'b0;
    bus.start = 1'b1; bus.func3 = F3_MUL; bus.op1 = 32'd6; bus.op2 = 32'd9; bus.rd = 5'd21;
    @(negedge clk);
    chk("flush busy@T+11", {31'd0, bus.busy},      32'd0);
    chk("flush no done",   {31'd0, bus.done},      32'd0);
    chk("flush result held", bus.result,           32'd0);
    chk("post-flush stall",{31'd0, bus.stall_req}, 32'd1);
    @(posedge clk); #1;                       // T+12
    bus.start = 1'b0;
    @(negedge clk);
    chk("post-flush done",   {31'd0, bus.done},      32'd1);
    chk("post-flush result", bus.result,             32'd54);
    chk("post-flush rd",     {27'd0, bus.result_rd}, 32'd21);

    // reset asserted at T+5 of a divide clears everything immediately
    @(posedge clk); #1;
    bus.start = 1'b1; bus.func3 = F3_DIVU; bus.op1 = 32'd1000; bus.op2 = 32'd3; bus.rd = 5'd22;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst busy",   {31'd0, bus.busy},      32'd0);
    chk("midrst done",   {31'd0, bus.done},      32'd0);
    chk("midrst stall",  {31'd0, bus.stall_req}, 32'd0);
    chk("midrst result", bus.result,             32'd0);
    chk("midrst rd",     {27'd0, bus.result_rd}, 32'd0);
    @(negedge clk); rst = 1'b1;
    run_op("DIVU post-rst", F3_DIVU, 32'd100, 32'd7, 5'd23, 32'd14, 33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
